// File: rtl/distributor2_pkg.sv
// Shared constants for the 1-to-2 registered distributor.
package distributor2_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 2;
  localparam int DEFAULT_CNT_W = 16;

  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;

endpackage

// File: rtl/distributor2_sync_fifo.sv
// Small synchronous FIFO with wrap-bit pointers; the head entry is read
// straight from registers so dout carries no logic from din.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Equal index with differing wrap bits means the writer lapped the reader.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    // NOTE: every output of this block is given a default first so no path leaves it unassigned (no latch).
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      // NOTE: the storage is reset too (it is tiny) so the head word reads 0 after reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/distributor2.sv
// 1-to-2 distributor: steers each accepted word into a per-port FIFO chosen
// by `sign`, and counts words delivered on each port.
module distributor2
  import distributor2_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign,
  input  logic [WIDTH-1:0] In,
  output logic             Out0_valid,
  input  logic             Out0_ready,
  output logic [WIDTH-1:0] Out0,
  output logic             Out1_valid,
  input  logic             Out1_ready,
  output logic [WIDTH-1:0] Out1,
  output logic             busy,
  output logic [CNT_W-1:0] Count0,
  output logic [CNT_W-1:0] Count1
);

  logic             full0, full1;
  logic             empty0, empty1;
  logic             accept;
  logic             push0, push1;
  logic             pop0, pop1;
  logic [CNT_W-1:0] count0_q, count0_d;
  logic [CNT_W-1:0] count1_q, count1_d;

  // Ready looks only at the selected FIFO's registered full flag, never at
  // the consumers, so output ready has no combinational path to input ready.
  assign in_ready = (sign == SEL_OUT1) ? !full1 : !full0;
  assign accept   = in_valid && in_ready;
  assign push0    = accept && (sign == SEL_OUT0);
  assign push1    = accept && (sign == SEL_OUT1);

  assign Out0_valid = !empty0;
  assign Out1_valid = !empty1;
  assign pop0       = Out0_valid && Out0_ready;
  assign pop1       = Out1_valid && Out1_ready;
  assign busy       = Out0_valid | Out1_valid;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .CLK   (CLK),
    .Reset (Reset),
    .push  (push0),
    .din   (In),
    .full  (full0),
    .pop   (pop0),
    .dout  (Out0),
    .empty (empty0)
  );

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .CLK   (CLK),
    .Reset (Reset),
    .push  (push1),
    .din   (In),
    .full  (full1),
    .pop   (pop1),
    .dout  (Out1),
    .empty (empty1)
  );

  always_comb begin
    count0_d = count0_q;
    count1_d = count1_q;
    if (pop0) count0_d = count0_q + CNT_W'(1);
    if (pop1) count1_d = count1_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      count0_q <= '0;
      count1_q <= '0;
    end else begin
      count0_q <= count0_d;
      count1_q <= count1_d;
    end
  end

  assign Count0 = count0_q;
  assign Count1 = count1_q;

endmodule

// File: tb/tb_distributor2.sv
// Directed bench for distributor2, built with CNT_W=4 so counter wrap is reachable.
module tb_distributor2;

  localparam int W  = 32;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          Reset;
  logic          in_valid;
  logic          in_ready;
  logic          sign;
  logic [W-1:0]  In;
  logic          Out0_valid, Out0_ready;
  logic [W-1:0]  Out0;
  logic          Out1_valid, Out1_ready;
  logic [W-1:0]  Out1;
  logic          busy;
  logic [CW-1:0] Count0, Count1;

  int total = 0;
  int bad   = 0;

  distributor2 #(.WIDTH(W), .DEPTH(2), .CNT_W(CW)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sign       (sign),
    .In         (In),
    .Out0_valid (Out0_valid),
    .Out0_ready (Out0_ready),
    .Out0       (Out0),
    .Out1_valid (Out1_valid),
    .Out1_ready (Out1_ready),
    .Out1       (Out1),
    .busy       (busy),
    .Count0     (Count0),
    .Count1     (Count1)
  );

  always #5 CLK = ~CLK;

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    @(posedge CLK);
    #1 Reset = 1'b0;
    in_valid   = 1'b0;
    Out0_ready = 1'b0;
    Out1_ready = 1'b0;
    #5 Reset = 1'b1;
    step();
  endtask

  task automatic test_reset;
    Reset = 1'b0; in_valid = 1'b0; sign = 1'b0; In = '0;
    Out0_ready = 1'b0; Out1_ready = 1'b0;
    #12 Reset = 1'b1;
    #1;
    total++; if (Out0_valid !== 1'b0) begin bad++; $display("FAIL rst_out0_valid got=%0b want=0", Out0_valid); end
    total++; if (Out1_valid !== 1'b0) begin bad++; $display("FAIL rst_out1_valid got=%0b want=0", Out1_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", busy); end
    total++; if (Out0 !== 32'h0 || Out1 !== 32'h0) begin bad++; $display("FAIL rst_data got=%h/%h want=0/0", Out0, Out1); end
    total++; if (Count0 !== 4'd0 || Count1 !== 4'd0) begin bad++; $display("FAIL rst_counts got=%0d/%0d want=0/0", Count0, Count1); end

    // Mid-stream reset: two words buffered on port 0, then Reset before any pop.
    step();
    in_valid = 1'b1; sign = 1'b0; In = 32'hAAAA0001;
    step();
    In = 32'hAAAA0002;
    step();
    in_valid = 1'b0;
    total++; if (Out0_valid !== 1'b1 || Out0 !== 32'hAAAA0001) begin bad++; $display("FAIL mid_buffered got=%0b/%h want=1/aaaa0001", Out0_valid, Out0); end
    Reset = 1'b0;
    #1;
    total++; if (Out0_valid !== 1'b0 || Out0 !== 32'h0) begin bad++; $display("FAIL mid_async_clear got=%0b/%h want=0/0", Out0_valid, Out0); end
    Out0_ready = 1'b1;
    #4 Reset = 1'b1;
    for (int i = 0; i < 3; i++) step();
    total++; if (Out0_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_after_release got=%0b/%0b want=0/0", Out0_valid, busy); end
    total++; if (Count0 !== 4'd0) begin bad++; $display("FAIL mid_count0 got=%0d want=0", Count0); end
  endtask

  task automatic test_routing;
    do_reset();
    Out0_ready = 1'b1; Out1_ready = 1'b1;
    in_valid = 1'b1; sign = 1'b0; In = 32'h11111111;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL route_ready got=%0b want=1", in_ready); end
    step();
    total++; if (Out0_valid !== 1'b1 || Out0 !== 32'h11111111) begin bad++; $display("FAIL route_out0 got=%0b/%h want=1/11111111", Out0_valid, Out0); end
    total++; if (Out1_valid !== 1'b0) begin bad++; $display("FAIL route_out1_idle got=%0b want=0", Out1_valid); end
    sign = 1'b1; In = 32'h22222222;
    step();
    in_valid = 1'b0;
    total++; if (Out1_valid !== 1'b1 || Out1 !== 32'h22222222) begin bad++; $display("FAIL route_out1 got=%0b/%h want=1/22222222", Out1_valid, Out1); end
    total++; if (Out0_valid !== 1'b0 || Count0 !== 4'd1) begin bad++; $display("FAIL route_pop0 got=%0b/%0d want=0/1", Out0_valid, Count0); end
    step();
    total++; if (Count1 !== 4'd1 || busy !== 1'b0) begin bad++; $display("FAIL route_done got=%0d/%0b want=1/0", Count1, busy); end
  endtask

  task automatic test_backpressure;
    do_reset();
    Out0_ready = 1'b0; Out1_ready = 1'b1;
    in_valid = 1'b1; sign = 1'b0; In = 32'hB0000001;
    step();
    In = 32'hB0000002;
    step();
    In = 32'hB0000003;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full0_ready got=%0b want=0", in_ready); end
    sign = 1'b1; In = 32'h33333333;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_port1_ready got=%0b want=1", in_ready); end
    step();
    total++; if (Out1_valid !== 1'b1 || Out1 !== 32'h33333333) begin bad++; $display("FAIL bp_out1 got=%0b/%h want=1/33333333", Out1_valid, Out1); end
    total++; if (Out0 !== 32'hB0000001) begin bad++; $display("FAIL bp_head_stable got=%h want=b0000001", Out0); end
    sign = 1'b0; In = 32'hB0000003;
    step();
    Out0_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_still_full got=%0b want=0", in_ready); end
    step();
    total++; if (in_ready !== 1'b1 || Out0 !== 32'hB0000002) begin bad++; $display("FAIL bp_released got=%0b/%h want=1/b0000002", in_ready, Out0); end
    step();
    in_valid = 1'b0;
    total++; if (Out0 !== 32'hB0000003) begin bad++; $display("FAIL bp_third got=%h want=b0000003", Out0); end
    step();
    total++; if (Count0 !== 4'd3 || Count1 !== 4'd1) begin bad++; $display("FAIL bp_counts got=%0d/%0d want=3/1", Count0, Count1); end
  endtask

  task automatic test_full_pop;
    do_reset();
    Out0_ready = 1'b0; Out1_ready = 1'b0;
    in_valid = 1'b1; sign = 1'b0; In = 32'hD0000001;
    step();
    In = 32'hD0000002;
    step();
    In = 32'hD0000003; Out0_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fp_refused got=%0b want=0", in_ready); end
    step();
    Out0_ready = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1 || Out0 !== 32'hD0000002) begin bad++; $display("FAIL fp_pop_only got=%0b/%h want=1/d0000002", in_ready, Out0); end
    step();
    in_valid = 1'b0;
    #1;
    total++; if (in_ready !== 1'b0 || Out0 !== 32'hD0000002) begin bad++; $display("FAIL fp_refilled got=%0b/%h want=0/d0000002", in_ready, Out0); end
    Out0_ready = 1'b1;
    step();
    total++; if (Out0 !== 32'hD0000003) begin bad++; $display("FAIL fp_last got=%h want=d0000003", Out0); end
    step();
    total++; if (Out0_valid !== 1'b0 || Count0 !== 4'd3) begin bad++; $display("FAIL fp_drained got=%0b/%0d want=0/3", Out0_valid, Count0); end
  endtask

  task automatic test_ordering;
    int idx = 0, n0 = 0, n1 = 0, stalls = 0;
    do_reset();
    for (int cyc = 0; cyc < 400 && (n0 < 5 || n1 < 5); cyc++) begin
      Out0_ready = 1'($urandom_range(0, 1));
      Out1_ready = 1'($urandom_range(0, 1));
      in_valid   = (idx < 10);
      In         = 32'(idx);
      sign       = idx[0];
      #1;
      if (Out0_valid && Out0_ready) begin
        total++; if (Out0 !== 32'(2 * n0)) begin bad++; $display("FAIL order_out0 got=%0d want=%0d", Out0, 2 * n0); end
        n0++;
      end
      if (Out1_valid && Out1_ready) begin
        total++; if (Out1 !== 32'(2 * n1 + 1)) begin bad++; $display("FAIL order_out1 got=%0d want=%0d", Out1, 2 * n1 + 1); end
        n1++;
      end
      if (in_valid && in_ready) idx++;
      step();
    end
    in_valid = 1'b0;
    total++; if (n0 != 5 || n1 != 5) begin bad++; $display("FAIL order_timeout got=%0d/%0d want=5/5", n0, n1); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL order_idle got=%0b want=0", busy); end

    // Both consumers always ready: one accept every cycle.
    do_reset();
    Out0_ready = 1'b1; Out1_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; In = 32'(i); sign = i[0];
      #1;
      if (!in_ready) stalls++;
      step();
    end
    in_valid = 1'b0;
    step();
    total++; if (stalls != 0) begin bad++; $display("FAIL tput_stalls got=%0d want=0", stalls); end
    total++; if (Count0 !== 4'd3 || Count1 !== 4'd3) begin bad++; $display("FAIL tput_counts got=%0d/%0d want=3/3", Count0, Count1); end
  endtask

  task automatic test_counter_wrap;
    do_reset();
    Out0_ready = 1'b1; Out1_ready = 1'b1;
    for (int j = 1; j <= 17; j++) begin
      in_valid = 1'b1; sign = 1'b1; In = 32'(j);
      step();
      if (j == 16) begin
        total++; if (Count1 !== 4'd15) begin bad++; $display("FAIL wrap_15 got=%0d want=15", Count1); end
      end
      if (j == 17) begin
        total++; if (Count1 !== 4'd0) begin bad++; $display("FAIL wrap_0 got=%0d want=0", Count1); end
        total++; if (Out1 !== 32'd17) begin bad++; $display("FAIL wrap_head got=%0d want=17", Out1); end
      end
    end
    in_valid = 1'b0;
    step();
    total++; if (Count1 !== 4'd1) begin bad++; $display("FAIL wrap_1 got=%0d want=1", Count1); end
    total++; if (Count0 !== 4'd0) begin bad++; $display("FAIL wrap_count0 got=%0d want=0", Count0); end
  endtask

  initial begin
    test_reset();
    test_routing();
    test_backpressure();
    test_full_pop();
    test_ordering();
    test_counter_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
